// File: rtl/exception_control_unit_if.sv
// Bundle of the exception sequencer's cause inputs, memory read data and the
// datapath-override outputs; master is the sequencer, slave is the datapath side.
interface exception_control_unit_if;
  logic        OPCode_Error;
  logic        Overflow;
  logic        AllowException;
  logic        Div_Zero;
  logic [31:0] PC_In;
  logic [7:0]  Mem_Data;

  logic        Exception_Signal;
  logic [1:0]  Exc_Cause;
  logic        EPC_Write;
  logic [31:0] EPC_Value;
  logic        Exc_Mem_Sel;
  logic [31:0] Exc_Mem_Addr;
  logic        PC_Load;
  logic [31:0] New_PC;
  logic        Exception_Done;

  modport master (
    input  OPCode_Error, Overflow, AllowException, Div_Zero, PC_In, Mem_Data,
    output Exception_Signal, Exc_Cause, EPC_Write, EPC_Value, Exc_Mem_Sel,
           Exc_Mem_Addr, PC_Load, New_PC, Exception_Done
  );

  modport slave (
    output OPCode_Error, Overflow, AllowException, Div_Zero, PC_In, Mem_Data,
    input  Exception_Signal, Exc_Cause, EPC_Write, EPC_Value, Exc_Mem_Sel,
           Exc_Mem_Addr, PC_Load, New_PC, Exception_Done
  );
endinterface

// File: rtl/exception_control_unit.sv
// Exception sequencer: saves PC-4 to EPC, fetches the handler byte from the
// cause vector and loads it into PC, owning the datapath for 3+MEM_LATENCY cycles.
module exception_control_unit #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned VEC_OPCODE   = 253,
  parameter int unsigned VEC_OVERFLOW = 254,
  parameter int unsigned VEC_DIVZERO  = 255
) (
  input  logic                        Clock,
  input  logic                        Reset,
  exception_control_unit_if.master    ecu
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
  localparam logic [1:0] CAUSE_DIVZERO  = 2'b11;
  localparam logic [3:0] WAIT_LAST      = 4'(MEM_LATENCY - 1);

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [1:0]  cause_reg;
  logic [31:0] epc_value_reg;
  logic        exc_signal_reg;
  logic        epc_write_reg;
  logic        mem_sel_reg;
  logic [31:0] mem_addr_reg;
  logic        pc_load_reg;
  logic        done_reg;

  logic [1:0]  trig_cause;
  logic        trig;

  // Fixed priority: opcode beats divide-by-zero beats qualified overflow.
  always_comb begin
    trig_cause = CAUSE_NONE;
    if (ecu.OPCode_Error)
      trig_cause = CAUSE_OPCODE;
    else if (ecu.Div_Zero)
      trig_cause = CAUSE_DIVZERO;
    else if (ecu.Overflow && ecu.AllowException)
      trig_cause = CAUSE_OVERFLOW;
  end

  assign trig = (trig_cause != CAUSE_NONE);

  function automatic logic [31:0] vector_addr(input logic [1:0] cause);
    case (cause)
      CAUSE_OPCODE:   vector_addr = 32'(VEC_OPCODE);
      CAUSE_OVERFLOW: vector_addr = 32'(VEC_OVERFLOW);
      CAUSE_DIVZERO:  vector_addr = 32'(VEC_DIVZERO);
      default:        vector_addr = 32'd0;
    endcase
  endfunction

  // Output registers are loaded with the values of the state being entered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg      <= S_IDLE;
      wait_cnt_reg   <= 4'd0;
      cause_reg      <= CAUSE_NONE;
      epc_value_reg  <= 32'd0;
      exc_signal_reg <= 1'b0;
      epc_write_reg  <= 1'b0;
      mem_sel_reg    <= 1'b0;
      mem_addr_reg   <= 32'd0;
      pc_load_reg    <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (trig) begin
            state_reg      <= S_SAVE;
            cause_reg      <= trig_cause;
            epc_value_reg  <= ecu.PC_In - 32'd4;
            exc_signal_reg <= 1'b1;
            epc_write_reg  <= 1'b1;
          end
        end
        S_SAVE: begin
          state_reg     <= S_WAIT;
          wait_cnt_reg  <= 4'd0;
          epc_write_reg <= 1'b0;
          mem_sel_reg   <= 1'b1;
          mem_addr_reg  <= vector_addr(cause_reg);
        end
        S_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 4'd1;
          if (wait_cnt_reg == WAIT_LAST) begin
            state_reg   <= S_LOAD;
            pc_load_reg <= 1'b1;
          end
        end
        S_LOAD: begin
          state_reg    <= S_DONE;
          pc_load_reg  <= 1'b0;
          mem_sel_reg  <= 1'b0;
          mem_addr_reg <= 32'd0;
          done_reg     <= 1'b1;
        end
        S_DONE: begin
          state_reg      <= S_IDLE;
          exc_signal_reg <= 1'b0;
          done_reg       <= 1'b0;
        end
        default: begin
          state_reg      <= S_IDLE;
          exc_signal_reg <= 1'b0;
          epc_write_reg  <= 1'b0;
          mem_sel_reg    <= 1'b0;
          mem_addr_reg   <= 32'd0;
          pc_load_reg    <= 1'b0;
          done_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign ecu.Exception_Signal = exc_signal_reg;
  assign ecu.Exc_Cause        = cause_reg;
  assign ecu.EPC_Write        = epc_write_reg;
  assign ecu.EPC_Value        = epc_value_reg;
  assign ecu.Exc_Mem_Sel      = mem_sel_reg;
  assign ecu.Exc_Mem_Addr     = mem_addr_reg;
  assign ecu.PC_Load          = pc_load_reg;
  // Handler byte is taken straight off the read bus during the load cycle.
  assign ecu.New_PC           = pc_load_reg ? {24'd0, ecu.Mem_Data} : 32'd0;
  assign ecu.Exception_Done   = done_reg;

  a_strobes_inside_sequence: assert property (
    @(posedge Clock) disable iff (Reset)
      (ecu.EPC_Write || ecu.PC_Load || ecu.Exception_Done) |-> ecu.Exception_Signal
  );

  a_single_strobe: assert property (
    @(posedge Clock) disable iff (Reset)
      $onehot0({ecu.EPC_Write, ecu.PC_Load, ecu.Exception_Done})
  );

endmodule

// File: tb/tb_exception_control_unit.sv
// Bench for exception_control_unit: two instances (latency 2 and 1) driven with
// identical stimulus and compared every cycle against a sequence-position model.
module tb_exception_control_unit;

  localparam int L0 = 2;
  localparam int L1 = 1;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        opc_i, ovf_i, allow_i, dz_i;
  logic [31:0] pc_i;

  always #5 Clock = ~Clock;

  exception_control_unit_if bus0 ();
  exception_control_unit_if bus1 ();

  exception_control_unit #(.MEM_LATENCY(L0)) dut0 (
    .Clock (Clock),
    .Reset (Reset),
    .ecu   (bus0.master)
  );

  exception_control_unit #(.MEM_LATENCY(L1)) dut1 (
    .Clock (Clock),
    .Reset (Reset),
    .ecu   (bus1.master)
  );

  assign bus0.OPCode_Error   = opc_i;
  assign bus0.Overflow       = ovf_i;
  assign bus0.AllowException = allow_i;
  assign bus0.Div_Zero       = dz_i;
  assign bus0.PC_In          = pc_i;
  assign bus1.OPCode_Error   = opc_i;
  assign bus1.Overflow       = ovf_i;
  assign bus1.AllowException = allow_i;
  assign bus1.Div_Zero       = dz_i;
  assign bus1.PC_In          = pc_i;

  // Memory with a fixed read latency; 8'hEE marks "no valid read yet".
  logic [7:0] mem [256];
  logic [8:0] pipe0 [L0];
  logic [8:0] pipe1 [L1];

  always @(posedge Clock) begin
    pipe0[0] <= {bus0.Exc_Mem_Sel, bus0.Exc_Mem_Addr[7:0]};
    for (int i = 1; i < L0; i++) pipe0[i] <= pipe0[i-1];
    pipe1[0] <= {bus1.Exc_Mem_Sel, bus1.Exc_Mem_Addr[7:0]};
    for (int i = 1; i < L1; i++) pipe1[i] <= pipe1[i-1];
  end

  assign bus0.Mem_Data = pipe0[L0-1][8] ? mem[pipe0[L0-1][7:0]] : 8'hEE;
  assign bus1.Mem_Data = pipe1[L1-1][8] ? mem[pipe1[L1-1][7:0]] : 8'hEE;

  int checks = 0;
  int errors = 0;

  // Model: position within the sequence (0 = idle, 1 = save ... lat+3 = done).
  int          pos_m   [2];
  logic [1:0]  cause_m [2];
  logic [31:0] epc_m   [2];
  int          sig_cnt [2];
  int          done_cnt[2];

  function automatic int lat(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [1:0] c;
    c = opc_i ? 2'd1 : dz_i ? 2'd3 : (ovf_i && allow_i) ? 2'd2 : 2'd0;
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        pos_m[k] = 0; cause_m[k] = 2'd0; epc_m[k] = 32'd0;
      end else if (pos_m[k] == 0) begin
        if (c != 2'd0) begin
          pos_m[k] = 1; cause_m[k] = c; epc_m[k] = pc_i - 32'd4;
        end
      end else if (pos_m[k] == lat(k) + 3) begin
        pos_m[k] = 0;
      end else begin
        pos_m[k]++;
      end
    end
  endtask

  task automatic check_dut(input int k);
    logic sig, ew, sel, pl, dn;
    logic [1:0] c;
    logic [31:0] ev, ad, np;
    int p;
    logic e_sel, e_pl;
    logic [31:0] e_addr;
    if (k == 0) begin
      sig = bus0.Exception_Signal; c = bus0.Exc_Cause; ew = bus0.EPC_Write; ev = bus0.EPC_Value;
      sel = bus0.Exc_Mem_Sel; ad = bus0.Exc_Mem_Addr; pl = bus0.PC_Load; np = bus0.New_PC;
      dn = bus0.Exception_Done;
    end else begin
      sig = bus1.Exception_Signal; c = bus1.Exc_Cause; ew = bus1.EPC_Write; ev = bus1.EPC_Value;
      sel = bus1.Exc_Mem_Sel; ad = bus1.Exc_Mem_Addr; pl = bus1.PC_Load; np = bus1.New_PC;
      dn = bus1.Exception_Done;
    end
    p      = pos_m[k];
    e_sel  = (p >= 2) && (p <= lat(k) + 2);
    e_pl   = (p == lat(k) + 2);
    e_addr = e_sel ? 32'd252 + 32'(cause_m[k]) : 32'd0;
    chk("exception_signal", k, 32'(sig), 32'(p != 0));
    chk("exc_cause",        k, 32'(c),   32'(cause_m[k]));
    chk("epc_write",        k, 32'(ew),  32'(p == 1));
    chk("epc_value",        k, ev,       epc_m[k]);
    chk("exc_mem_sel",      k, 32'(sel), 32'(e_sel));
    chk("exc_mem_addr",     k, ad,       e_addr);
    chk("pc_load",          k, 32'(pl),  32'(e_pl));
    chk("new_pc",           k, np,       e_pl ? {24'd0, mem[e_addr[7:0]]} : 32'd0);
    chk("exception_done",   k, 32'(dn),  32'(p == lat(k) + 3));
    if (sig) sig_cnt[k]++;
    if (dn)  done_cnt[k]++;
  endtask

  task automatic step();
    @(posedge Clock);
    model_update();
    @(negedge Clock);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic set_in(input logic o, input logic v, input logic a, input logic d, input logic [31:0] p);
    opc_i = o; ovf_i = v; allow_i = a; dz_i = d; pc_i = p;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  typedef struct {
    logic        opc, ovf, allow, dz;
    logic [31:0] pc;
    logic        exp_busy;
    logic [1:0]  exp_cause;
    logic [31:0] exp_addr, exp_epc, exp_npc;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 2'd1, 32'd253, 32'h0000_000C, 32'h40};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 1'b0, 2'd0, 32'd0,   32'h0,         32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 2'd2, 32'd254, 32'h0000_00FC, 32'h9A};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 1'b1, 2'd1, 32'd253, 32'h0000_1FFC, 32'h40};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0044, 1'b1, 2'd3, 32'd255, 32'h0000_0040, 32'h7F};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 2'd1, 32'd253, 32'hFFFF_FFFC, 32'h40};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd3, 32'd255, 32'hDEAD_BEEB, 32'h7F};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[253] = 8'h40; mem[254] = 8'h9A; mem[255] = 8'h7F;
    for (int i = 0; i < L0; i++) pipe0[i] = 9'd0;
    for (int i = 0; i < L1; i++) pipe1[i] = 9'd0;
    for (int k = 0; k < 2; k++) begin
      pos_m[k] = 0; cause_m[k] = 2'd0; epc_m[k] = 32'd0; sig_cnt[k] = 0; done_cnt[k] = 0;
    end
    set_in(0, 0, 0, 0, 32'd0);

    // Table: one-cycle trigger from a freshly reset IDLE, then the whole sequence.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      step();
      sig_cnt = '{0, 0};
      set_in(vecs[v].opc, vecs[v].ovf, vecs[v].allow, vecs[v].dz, vecs[v].pc);
      step();
      set_in(0, 0, 0, 0, 32'd0);
      chk("tbl_busy",  0, 32'(bus0.Exception_Signal), 32'(vecs[v].exp_busy));
      chk("tbl_cause", 0, 32'(bus0.Exc_Cause), 32'(vecs[v].exp_cause));
      chk("tbl_epc",   0, bus0.EPC_Value, vecs[v].exp_epc);
      step();
      chk("tbl_addr",  0, bus0.Exc_Mem_Addr, vecs[v].exp_addr);
      step();
      step();
      chk("tbl_pc_load", 0, 32'(bus0.PC_Load), 32'(vecs[v].exp_busy));
      chk("tbl_new_pc",  0, bus0.New_PC, vecs[v].exp_npc);
      step();
      step();
      step();
      chk("tbl_len_lat2", 0, 32'(sig_cnt[0]), vecs[v].exp_busy ? 32'd5 : 32'd0);
      chk("tbl_len_lat1", 1, 32'(sig_cnt[1]), vecs[v].exp_busy ? 32'd4 : 32'd0);
      chk("tbl_cause_held", 0, 32'(bus0.Exc_Cause), 32'(vecs[v].exp_cause));
    end

    // New triggers during WAIT are ignored.
    do_reset();
    set_in(1, 0, 0, 0, 32'h0000_0080);
    step();
    set_in(0, 0, 0, 0, 32'd0);
    step();
    set_in(1, 1, 1, 1, 32'h0000_0900);
    step();
    set_in(0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("ignored_cause", 0, 32'(bus0.Exc_Cause), 32'd1);
    chk("ignored_epc",   0, bus0.EPC_Value, 32'h0000_007C);
    chk("ignored_idle",  0, 32'(bus0.Exception_Signal), 32'd0);

    // A held trigger restarts right after DONE.
    do_reset();
    done_cnt = '{0, 0};
    set_in(0, 0, 0, 1, 32'h0000_1234);
    for (int i = 0; i < 12; i++) step();
    chk("back_to_back_done", 0, 32'(done_cnt[0]), 32'd2);
    chk("back_to_back_done", 1, 32'(done_cnt[1]), 32'd2);
    set_in(0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 6; i++) step();

    // Reset in WAIT aborts the sequence.
    do_reset();
    set_in(1, 0, 0, 0, 32'h0000_0040);
    step();
    set_in(0, 0, 0, 0, 32'd0);
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("abort_signal",  0, 32'(bus0.Exception_Signal), 32'd0);
    chk("abort_pc_load", 0, 32'(bus0.PC_Load), 32'd0);
    chk("abort_cause",   0, 32'(bus0.Exc_Cause), 32'd0);
    for (int i = 0; i < 4; i++) step();

    // Reset wins over a trigger in the same cycle.
    Reset = 1'b1;
    set_in(1, 1, 1, 1, 32'h0000_0400);
    step();
    Reset = 1'b0;
    set_in(0, 0, 0, 0, 32'd0);
    step();
    chk("reset_vs_trig", 0, 32'(bus0.Exception_Signal), 32'd0);
    chk("reset_vs_trig", 1, 32'(bus1.Exception_Signal), 32'd0);

    // Random traffic against the model.
    mem[253] = 8'($urandom); mem[254] = 8'($urandom); mem[255] = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 63) == 0);
      set_in($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             1'($urandom), $urandom_range(0, 7) == 0, $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_control_unit.md
Name: exception_control_unit

Overview:
- Exception sequencer directly upstream of the multicycle control unit; it generates the Exception_Signal that the control unit consumes.
- Detects three causes: nonexistent opcode, ALU overflow (only when the control unit allows it) and divide-by-zero.
- While handling an exception it takes ownership of the EPC, memory-address and PC-load paths:
  - saves the faulting PC - 4 into EPC;
  - reads the handler byte from the cause-specific vector address;
  - loads PC with that byte zero-extended.
- When the sequence ends it releases control back to the control unit.

Parameters:
- MEM_LATENCY, 2, cycles from a read address being presented to Mem_Data being valid (1..15).
- VEC_OPCODE, 253, byte address of the handler entry for a nonexistent opcode.
- VEC_OVERFLOW, 254, byte address of the handler entry for overflow.
- VEC_DIVZERO, 255, byte address of the handler entry for divide-by-zero.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- OPCode_Error  in  1  nonexistent opcode detected by the control unit.
- Overflow  in  1  ALU overflow flag.
- AllowException  in  1  qualifies Overflow; 0 means Overflow is ignored.
- Div_Zero  in  1  divisor-zero flag from the divider.
- PC_In  in  32  current PC, already incremented by fetch.
- Mem_Data  in  8  low byte of the memory read data.
- Exception_Signal  out  1  high while the sequence owns the datapath.
- Exc_Cause  out  2  00 none, 01 opcode, 10 overflow, 11 div-zero.
- EPC_Write  out  1  one-cycle write strobe for EPC.
- EPC_Value  out  32  value written to EPC.
- Exc_Mem_Sel  out  1  selects Exc_Mem_Addr on the memory address mux.
- Exc_Mem_Addr  out  32  vector address, zero-extended.
- PC_Load  out  1  one-cycle PC write strobe.
- New_PC  out  32  handler PC.
- Exception_Done  out  1  one-cycle pulse at the end of the sequence.

Behaviour:
- Reset behaviour:
  - Reset has priority over everything, including a trigger in the same cycle.
  - On Reset: state IDLE, all outputs 0, latched cause, latched PC and wait counter all cleared.
  - Reset mid-sequence aborts immediately; no further strobes are issued.
- Trigger (sampled only in IDLE at a rising edge):
  - trig = OPCode_Error | Div_Zero | (Overflow & AllowException).
  - Priority when several are set: OPCode_Error > Div_Zero > Overflow.
  - Only the winning cause is latched into Exc_Cause; the others are dropped, with no queueing.
- Capture: on the triggering edge, latch PC_In and the cause, then move to SAVE.
- Triggers arriving while state != IDLE are ignored.
- States and per-cycle outputs:
  - IDLE: all outputs 0; Exc_Cause holds the last cause until the next trigger or Reset.
  - SAVE (1 cycle): Exception_Signal=1, EPC_Write=1, EPC_Value = latched PC - 32'd4 (mod 2^32; PC=0 gives 32'hFFFFFFFC). Next state is WAIT with counter = 0.
  - WAIT (MEM_LATENCY cycles): Exception_Signal=1, Exc_Mem_Sel=1, Exc_Mem_Addr = vector for the latched cause. The counter increments each cycle; when counter == MEM_LATENCY-1 the next state is LOAD.
  - LOAD (1 cycle): Exception_Signal=1, Exc_Mem_Sel=1, PC_Load=1, New_PC = {24'b0, Mem_Data} sampled combinationally this cycle. Next state is DONE.
  - DONE (1 cycle): Exception_Signal=1, Exception_Done=1. Next state is IDLE.
- Outputs are registered, i.e. they reflect the current state.
- EPC_Value is held after SAVE until the next trigger.
- Latency: from the trigger edge, Exception_Signal is high for 3 + MEM_LATENCY cycles. PC_Load occurs in cycle 2 + MEM_LATENCY after SAVE begins, counting SAVE as cycle 1.
- Back-to-back: a trigger present in the first IDLE cycle after DONE is accepted.
- Counter is 4 bits wide.

Test Plan:
1. Reset, then OPCode_Error=1 for 1 cycle with PC_In=32'h0000_0010 and MEM_LATENCY=2, memory returning byte 8'h40 at address 253 → SAVE with EPC_Value=32'h0000_000C and EPC_Write pulse; WAIT for 2 cycles with Exc_Mem_Addr=253; LOAD with New_PC=32'h0000_0040 and PC_Load pulse; DONE pulse; Exception_Signal high for exactly 5 cycles; Exc_Cause=01.
2. Overflow=1 with AllowException=0 → remains IDLE, all outputs 0. Repeat with AllowException=1 → Exc_Cause=10, Exc_Mem_Addr=254.
3. OPCode_Error, Div_Zero and Overflow (allowed) all asserted in the same cycle → Exc_Cause=01 and address 253. Div_Zero with Overflow → Exc_Cause=11, address 255.
4. New OPCode_Error pulsed during WAIT → ignored; sequence length and Exc_Cause unchanged. Trigger held through DONE into IDLE → a second sequence starts on the next edge.
5. Reset asserted in the WAIT cycle → next cycle all outputs 0, no PC_Load. A trigger together with Reset in the same cycle → stays IDLE.
6. PC_In=32'h0000_0000 → EPC_Value=32'hFFFF_FFFC. With MEM_LATENCY=1, Exception_Signal is high for 4 cycles.
